// File: rtl/calc_pkg.sv
// Shared definitions for the arithmetic datapath: FSM encoding, BCD digit
// width and default operand widths so the multiplier and converter agree.
package calc_pkg;

  localparam int BCD_W         = 4;
  localparam int BIN_WIDTH_DEF = 32;
  localparam int DIGITS_DEF    = 10;
  localparam int NUM_DIGITS_W  = 4;
  localparam int PRODUCT_W     = BIN_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_bcd_if.sv
// Start/completed handshake bundle between the multiplier side, the
// binary-to-BCD converter and the display driver.
interface bin_to_bcd_if
  import calc_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF,
  parameter int DIGITS    = DIGITS_DEF
);

  logic                    start;
  logic [BIN_WIDTH-1:0]    bin_in;
  logic [BCD_W*DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS_W-1:0] num_digits;
  logic                    busy;
  logic                    completed;

  modport master (
    output start, bin_in,
    input  bcd_out, num_digits, busy, completed
  );

  modport slave (
    input  start, bin_in,
    output bcd_out, num_digits, busy, completed
  );

endinterface

// File: rtl/bin_to_bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  // Inputs are 0..9, so the 4-bit sum never overflows.
  assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one shift per clock, result and
// significant-digit count registered in a single DONE cycle.
module bin_to_bcd
  import calc_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF,
  parameter int DIGITS    = DIGITS_DEF
) (
  input  logic         clock,
  input  logic         rst,
  bin_to_bcd_if.slave  bus
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int COUNT_W  = $clog2(BIN_WIDTH + 1);
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(BIN_WIDTH - 1);

  state_t                  state_reg, state_next;
  logic [BCD_BITS-1:0]     bcd_reg, bcd_next;
  logic [BIN_WIDTH-1:0]    bin_reg, bin_next;
  logic [COUNT_W-1:0]      count_reg, count_next;
  logic [BCD_BITS-1:0]     bcd_out_reg, bcd_out_next;
  logic [NUM_DIGITS_W-1:0] num_digits_reg, num_digits_next;
  logic                    busy_reg, busy_next;
  logic                    completed_reg, completed_next;

  logic [BCD_BITS-1:0]     bcd_adj;
  logic [NUM_DIGITS_W-1:0] sig_digits;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (bcd_reg[gi*BCD_W +: BCD_W]),
        .dout (bcd_adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // Highest nonzero digit wins; an all-zero value still shows one digit.
  always_comb begin
    sig_digits = NUM_DIGITS_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_reg[i*BCD_W +: BCD_W] != '0) begin
        sig_digits = NUM_DIGITS_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    bcd_next        = bcd_reg;
    bin_next        = bin_reg;
    count_next      = count_reg;
    bcd_out_next    = bcd_out_reg;
    num_digits_next = num_digits_reg;
    busy_next       = busy_reg;
    completed_next  = completed_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          bcd_next       = '0;
          bin_next       = bus.bin_in;
          count_next     = '0;
          busy_next      = 1'b1;
          completed_next = 1'b0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        // Shift {adjusted bcd, bin} left by one; the bcd MSB falls off.
        bcd_next   = {bcd_adj[BCD_BITS-2:0], bin_reg[BIN_WIDTH-1]};
        bin_next   = {bin_reg[BIN_WIDTH-2:0], 1'b0};
        count_next = count_reg + COUNT_W'(1);
        if (count_reg == LAST_COUNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bcd_out_next    = bcd_reg;
        num_digits_next = sig_digits;
        busy_next       = 1'b0;
        completed_next  = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg      <= IDLE;
      bcd_reg        <= '0;
      bin_reg        <= '0;
      count_reg      <= '0;
      bcd_out_reg    <= '0;
      num_digits_reg <= NUM_DIGITS_W'(1);
      busy_reg       <= 1'b0;
      completed_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bcd_reg        <= bcd_next;
      bin_reg        <= bin_next;
      count_reg      <= count_next;
      bcd_out_reg    <= bcd_out_next;
      num_digits_reg <= num_digits_next;
      busy_reg       <= busy_next;
      completed_reg  <= completed_next;
    end
  end

  assign bus.bcd_out    = bcd_out_reg;
  assign bus.num_digits = num_digits_reg;
  assign bus.busy       = busy_reg;
  assign bus.completed  = completed_reg;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Randomised scoreboard bench for bin_to_bcd: expected results are queued on
// each accepted start and matched by a monitor on every rising completed.
module tb_bin_to_bcd;

  localparam int BW      = 32;
  localparam int ND      = 10;
  localparam int LATENCY = BW + 1;
  localparam int PERIOD  = BW + 2;

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic [3:0]      nd;
    int              cyc;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   free_at = 0;
  exp_t sb[$];
  logic prev_completed = 1'b0;

  bin_to_bcd_if #(.BIN_WIDTH(BW), .DIGITS(ND)) bus ();

  bin_to_bcd #(.BIN_WIDTH(BW), .DIGITS(ND)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: decimal digits by repeated division.
  function automatic logic [4*ND-1:0] ref_bcd(input longint unsigned v);
    logic [4*ND-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_nd(input longint unsigned v);
    int n;
    n = 1;
    v = v / 10;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return 4'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // One clock of stimulus; the bench decides on its own whether the DUT is
  // idle and therefore whether this start is accepted.
  task automatic step(input logic s, input logic [BW-1:0] v, input logic r);
    exp_t e;
    @(negedge clock);
    bus.start  = s;
    bus.bin_in = v;
    rst        = r;
    @(posedge clock);
    #1;
    if (r) begin
      sb.delete();
      free_at = cyc + 1;
    end else if (s && cyc >= free_at) begin
      e.bcd = ref_bcd(longint'(v));
      e.nd  = ref_nd(longint'(v));
      e.cyc = cyc;
      sb.push_back(e);
      free_at = cyc + PERIOD;
      $display("start accepted: bin_in=%0d at cycle %0d", v, cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * PERIOD) begin
      step(1'b0, '0, 1'b0);
      n++;
    end
    step(1'b0, '0, 1'b0);
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every rising completed must match the oldest queued result.
  always @(negedge clock) begin
    exp_t e;
    if (bus.completed && !prev_completed) begin
      if (sb.size() == 0) begin
        check("unexpected_completed", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("bcd_out", 64'(bus.bcd_out), 64'(e.bcd));
        check("num_digits", 64'(bus.num_digits), 64'(e.nd));
        check("latency", 64'(cyc - e.cyc), 64'(LATENCY));
        check("busy_low_at_done", 64'(bus.busy), 64'd0);
      end
    end
    prev_completed = bus.completed;
  end

  initial begin
    logic [BW-1:0] v;
    int gap;
    bus.start  = 1'b0;
    bus.bin_in = '0;

    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_completed", 64'(bus.completed), 64'd0);
    check("rst_bcd_out", 64'(bus.bcd_out), 64'd0);
    check("rst_num_digits", 64'(bus.num_digits), 64'd1);
    step(1'b0, '0, 1'b0);

    // Directed values, including zero and all-ones.
    step(1'b1, 32'd1092, 1'b0);
    drain();
    step(1'b1, 32'd0, 1'b0);
    drain();
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Start while busy is ignored; bcd_out holds until the next accept.
    step(1'b1, 32'd9, 1'b0);
    repeat (9) step(1'b0, '0, 1'b0);
    step(1'b1, 32'd500, 1'b0);
    drain();
    repeat (3) step(1'b0, '0, 1'b0);
    check("hold_bcd_out", 64'(bus.bcd_out), 64'h9);
    check("hold_completed", 64'(bus.completed), 64'd1);
    step(1'b1, 32'd10, 1'b0);
    check("accept_clears_completed", 64'(bus.completed), 64'd0);
    check("accept_keeps_bcd_out", 64'(bus.bcd_out), 64'h9);
    check("accept_sets_busy", 64'(bus.busy), 64'd1);
    drain();

    // Reset in the middle of a conversion.
    step(1'b1, 32'd123456, 1'b0);
    repeat (14) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_completed", 64'(bus.completed), 64'd0);
    check("abort_bcd_out", 64'(bus.bcd_out), 64'd0);
    check("abort_num_digits", 64'(bus.num_digits), 64'd1);
    step(1'b1, 32'd7, 1'b0);
    drain();

    // Multiplier handoff: a one-cycle completed pulse carrying the product.
    repeat (4) step(1'b0, '0, 1'b0);
    v = 32'(64'hFFFF * 64'hFFFF);
    step(1'b1, v, 1'b0);
    drain();

    // Start held high: restarts on every IDLE visit, bin_in changing freely.
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step(1'b1, $urandom, 1'b0);
    end
    drain();

    // Random values and gaps; short gaps exercise ignored starts.
    for (int i = 0; i < 25; i++) begin
      v = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 99999));
      step(1'b1, v, 1'b0);
      gap = $urandom_range(0, 45);
      for (int k = 0; k < gap; k++) step(1'b0, $urandom, 1'b0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
